// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshakes.
// Groups of 4 bits feed a second lookahead tier; optional register splits P/G from carry resolve.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [1:0]       op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int unsigned NG = WIDTH / 4;
    localparam int unsigned NT = (NG + 3) / 4;

    // Sum-of-products carry into position n (0..4) of a 4-wide lookahead block.
    function automatic logic lookahead(input logic [3:0] g, input logic [3:0] p,
                                       input logic c0, input int unsigned n);
        logic r;
        logic prod;
        r = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < n) begin
                prod = g[i];
                for (int unsigned m = 0; m < 4; m++) begin
                    if (m > i && m < n) prod = prod & p[m];
                end
                r = r | prod;
            end
        end
        prod = c0;
        for (int unsigned m = 0; m < 4; m++) begin
            if (m < n) prod = prod & p[m];
        end
        return r | prod;
    endfunction

    logic [WIDTH-1:0] bb, p0, g0;
    logic             ci0;
    logic [NG-1:0]    gg0, pg0;

    always_comb begin
        bb  = op_i[0] ? ~b_i : b_i;
        ci0 = op_i[1] ? cin_i : op_i[0];
        p0  = a_i ^ bb;
        g0  = a_i & bb;
        for (int unsigned k = 0; k < NG; k++) begin
            gg0[k] = lookahead(g0[4*k +: 4], p0[4*k +: 4], 1'b0, 4);
            pg0[k] = &p0[4*k +: 4];
        end
    end

    logic             out_valid_q;
    logic             out_ld;
    logic [WIDTH-1:0] s_p, s_g;
    logic [NG-1:0]    s_gg, s_pg;
    logic             s_ci, s_valid;

    assign out_ld = !out_valid_q || out_ready_i;

    if (PIPE != 0) begin : g_pipe
        logic [WIDTH-1:0] p_q, g_q;
        logic [NG-1:0]    gg_q, pg_q;
        logic             ci_q, valid_q;
        logic             s1_ld;

        assign s1_ld = !valid_q || out_ld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                p_q     <= '0;
                g_q     <= '0;
                gg_q    <= '0;
                pg_q    <= '0;
                ci_q    <= 1'b0;
            end else if (s1_ld) begin
                valid_q <= in_valid_i;
                if (in_valid_i) begin
                    p_q  <= p0;
                    g_q  <= g0;
                    gg_q <= gg0;
                    pg_q <= pg0;
                    ci_q <= ci0;
                end
            end
        end

        assign in_ready_o = s1_ld;
        assign s_p        = p_q;
        assign s_g        = g_q;
        assign s_gg       = gg_q;
        assign s_pg       = pg_q;
        assign s_ci       = ci_q;
        assign s_valid    = valid_q;
    end else begin : g_nopipe
        assign in_ready_o = out_ld;
        assign s_p        = p0;
        assign s_g        = g0;
        assign s_gg       = gg0;
        assign s_pg       = pg0;
        assign s_ci       = ci0;
        assign s_valid    = in_valid_i;
    end

    logic [4*NT-1:0]  gg_pad, pg_pad;
    logic [4*NT:0]    gc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;

    // Group carries resolved per tier of 4 groups; tiers chain on their carry-out only.
    always_comb begin
        gg_pad         = '0;
        pg_pad         = '0;
        gg_pad[NG-1:0] = s_gg;
        pg_pad[NG-1:0] = s_pg;
        gc             = '0;
        gc[0]          = s_ci;
        for (int unsigned t = 0; t < NT; t++) begin
            for (int unsigned j = 1; j <= 4; j++) begin
                gc[4*t+j] = lookahead(gg_pad[4*t +: 4], pg_pad[4*t +: 4], gc[4*t], j);
            end
        end
        c = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                c[4*k+j] = lookahead(s_g[4*k +: 4], s_p[4*k +: 4], gc[k], j);
            end
        end
        c[WIDTH] = gc[NG];
        sum_d    = s_p ^ c[WIDTH-1:0];
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, zero_q, neg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (out_ld) begin
            out_valid_q <= s_valid;
            if (s_valid) begin
                sum_q  <= sum_d;
                cout_q <= c[WIDTH];
                ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
                zero_q <= (sum_d == '0);
                neg_q  <= sum_d[WIDTH-1];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
    assign zero_o      = zero_q;
    assign neg_o       = neg_q;

endmodule
